// File: rtl/sc_transition_count_scheduler.sv
// sc_transition_count_scheduler
// Round-robin arbiter for game-event increment requests. The granted amount is
// turned into a train of active-low enable pulses for the shared up-counter.
// The result is then compared with a level threshold. On a hit the counter is
// cleared and the level register advances.

module sc_transition_count_scheduler #(
   parameter int DATAWIDTH = 8,
   parameter int REQ_N     = 2,
   parameter int AMT_W     = 4,
   parameter int THRESHOLD = 10,
   parameter int LEVEL_W   = 3
) (
   input  logic                     SC_upTRANSITIONCOUNTER1_CLOCK_50,
   input  logic                     SC_upTRANSITIONCOUNTERR1_RESET_InHigh,
   input  logic [REQ_N-1:0]         req_InBUS,
   input  logic [REQ_N*AMT_W-1:0]   amount_InBUS,
   input  logic [DATAWIDTH-1:0]     count_InBUS,
   output logic                     upcount_OutLow,
   output logic                     clear_OutHigh,
   output logic [REQ_N-1:0]         grant_OutBUS,
   output logic [REQ_N-1:0]         done_OutBUS,
   output logic                     levelup_OutHigh,
   output logic [LEVEL_W-1:0]       level_OutBUS,
   output logic                     busy_OutHigh
);

   localparam int                   PTR_W      = (REQ_N > 1) ? $clog2(REQ_N) : 1;
   localparam logic [PTR_W-1:0]     LAST_IDX   = PTR_W'(REQ_N - 1);
   localparam logic [DATAWIDTH:0]   THRESH_EXT = (DATAWIDTH + 1)'(THRESHOLD);
   localparam logic [LEVEL_W-1:0]   LEVEL_MAX  = {LEVEL_W{1'b1}};

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_COUNT,
      ST_CHECK,
      ST_CLEAR,
      ST_DONE
   } state_t;

   state_t               state_q, state_d;
   logic [REQ_N-1:0]     grant_q, grant_d;
   logic [REQ_N-1:0]     done_q, done_d;
   logic [AMT_W-1:0]     rem_q, rem_d;
   logic [PTR_W-1:0]     ptr_q, ptr_d;
   logic [LEVEL_W-1:0]   level_q, level_d;
   logic                 clear_q, clear_d;
   logic                 levelup_q, levelup_d;

   logic                 win_found;
   logic [PTR_W-1:0]     win_idx;
   logic [PTR_W-1:0]     cand;
   logic [AMT_W-1:0]     win_amt;
   logic [REQ_N-1:0]     win_onehot;
   logic [PTR_W-1:0]     served_idx;
   logic                 count_sat;
   logic                 count_hit;

   assign count_sat = &count_InBUS;
   assign count_hit = ({1'b0, count_InBUS} >= THRESH_EXT);

   // Round-robin search: first requesting source after the pointer, wrapping
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = ptr_q;
      for (int k = 0; k < REQ_N; k++) begin
         cand = (cand == LAST_IDX) ? '0 : cand + PTR_W'(1);
         if (!win_found && req_InBUS[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   // Winner amount/one-hot selection and the index of the source in service
   always_comb begin
      win_amt    = '0;
      win_onehot = '0;
      served_idx = ptr_q;
      for (int i = 0; i < REQ_N; i++) begin
         if (win_idx == PTR_W'(i)) begin
            win_amt       = amount_InBUS[i*AMT_W +: AMT_W];
            win_onehot[i] = win_found;
         end
         if (grant_q[i]) begin
            served_idx = PTR_W'(i);
         end
      end
   end

   // State and output flops; a reset aborts any service in progress
   always_ff @(posedge SC_upTRANSITIONCOUNTER1_CLOCK_50 or posedge SC_upTRANSITIONCOUNTERR1_RESET_InHigh) begin
      if (SC_upTRANSITIONCOUNTERR1_RESET_InHigh) begin
         state_q   <= ST_IDLE;
         grant_q   <= '0;
         done_q    <= '0;
         rem_q     <= '0;
         ptr_q     <= LAST_IDX;
         level_q   <= '0;
         clear_q   <= 1'b0;
         levelup_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         done_q    <= done_d;
         rem_q     <= rem_d;
         ptr_q     <= ptr_d;
         level_q   <= level_d;
         clear_q   <= clear_d;
         levelup_q <= levelup_d;
      end
   end

   // Next-state sequencing of a single service
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (win_found) begin
               state_d = (win_amt != '0) ? ST_COUNT : ST_CHECK;
            end
         end
         ST_COUNT: begin
            if (rem_q == AMT_W'(1)) begin
               state_d = ST_CHECK;
            end
         end
         ST_CHECK: state_d = count_hit ? ST_CLEAR : ST_DONE;
         ST_CLEAR: state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Datapath and registered outputs, computed from the upcoming state so the
   // clear line (an async reset into the counter) comes straight off a flop
   always_comb begin
      grant_d = grant_q;
      rem_d   = rem_q;
      ptr_d   = ptr_q;
      level_d = level_q;
      case (state_q)
         ST_IDLE: begin
            if (win_found) begin
               grant_d = win_onehot;
               rem_d   = win_amt;
            end
         end
         ST_COUNT: rem_d = rem_q - AMT_W'(1);
         ST_CLEAR: begin
            if (level_q != LEVEL_MAX) begin
               level_d = level_q + LEVEL_W'(1);
            end
         end
         ST_DONE: begin
            ptr_d   = served_idx;
            grant_d = '0;
         end
         default: ;
      endcase
      clear_d   = (state_d == ST_CLEAR);
      levelup_d = (state_d == ST_CLEAR);
      done_d    = (state_d == ST_DONE) ? grant_d : '0;
   end

   assign upcount_OutLow  = !((state_q == ST_COUNT) && !count_sat);
   assign clear_OutHigh   = clear_q;
   assign levelup_OutHigh = levelup_q;
   assign grant_OutBUS    = grant_q;
   assign done_OutBUS     = done_q;
   assign level_OutBUS    = level_q;
   assign busy_OutHigh    = (state_q != ST_IDLE);

endmodule
